// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NREQ word sources.
// Each grant captures the winner's word and sends a three-byte frame:
// header {TAG, source index}, then the low data byte, then the high data byte.
module uart_tx_frame_arbiter #(
  parameter int         NREQ    = 2,
  parameter int         NBITS_D = 16,
  parameter int         DBIT    = 8,
  parameter logic [3:0] TAG     = 4'hA
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*NBITS_D-1:0]   i_data,
  output logic [NREQ-1:0]           o_grant,
  output logic                      o_busy,
  output logic                      o_tx_start,
  output logic [DBIT-1:0]           o_tx_data,
  input  logic                      i_tx_done,
  output logic [7:0]                o_frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    S_HDR,
    W_HDR,
    S_LO,
    W_LO,
    S_HI,
    W_HI
  } state_t;

  state_t               state_reg;
  logic [NBITS_D-1:0]   word_reg;
  logic [3:0]           last_reg;

  // Requests and words padded out to 16 sources so a 4-bit index is always in range.
  logic [15:0]          req_pad;
  logic [NBITS_D-1:0]   data_words [16];

  logic                 found;
  logic [3:0]           winner;
  logic [4:0]           cand;

  assign req_pad = 16'(i_req);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_words
      if (gi < NREQ) begin : g_used
        assign data_words[gi] = i_data[gi*NBITS_D +: NBITS_D];
      end else begin : g_unused
        assign data_words[gi] = '0;
      end
    end
  endgenerate

  // Round-robin search: start just after the last winner and take the first request found.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_reg} + 5'(i);
      if (cand >= 5'(NREQ)) begin
        cand = cand - 5'(NREQ);
      end
      if (!found && req_pad[cand[3:0]]) begin
        found  = 1'b1;
        winner = cand[3:0];
      end
    end
  end

  // Frame sequencer; every output is a register updated on the state transition.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      last_reg    <= 4'(NREQ - 1);
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_frame_cnt <= '0;
    end else begin
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            word_reg   <= data_words[winner];
            last_reg   <= winner;
            o_grant    <= NREQ'(1) << winner;
            o_busy     <= 1'b1;
            o_tx_start <= 1'b1;
            o_tx_data  <= DBIT'({TAG, winner});
            state_reg  <= S_HDR;
          end
        end
        S_HDR: state_reg <= W_HDR;
        W_HDR: begin
          if (i_tx_done) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= word_reg[DBIT-1:0];
            state_reg  <= S_LO;
          end
        end
        S_LO: state_reg <= W_LO;
        W_LO: begin
          if (i_tx_done) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= word_reg[2*DBIT-1:DBIT];
            state_reg  <= S_HI;
          end
        end
        S_HI: state_reg <= W_HI;
        W_HI: begin
          if (i_tx_done) begin
            o_busy      <= 1'b0;
            o_frame_cnt <= o_frame_cnt + 8'd1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame_arbiter.md
# uart_tx_frame_arbiter

Round-robin scheduler that shares the single `uart_tx` transmitter between several word-sized requesters, e.g. the BIP accumulator dump plus debug sources such as the PC or a cycle counter. Each granted request is captured and sent as a three-byte frame: tag byte, low data byte, high data byte. The block sits between the requesters and `uart_tx`, driving its `i_tx_start`/`i_din` and consuming its `o_tx_done`. It replaces ad-hoc per-source send sequencers at top level.

## Interface
- `NREQ`, 2: number of requesters, 1..16.
- `NBITS_D`, 16: requester word width; fixed at 2*`DBIT`.
- `DBIT`, 8: UART data byte width.
- `TAG`, 4'hA: upper nibble of the header byte.

- `i_clk`  in  1  system clock, same clock as `uart_tx`.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  `NREQ`  level request per source; held until granted.
- `i_data`  in  `NREQ*NBITS_D`  source words, source k at bits [k*`NBITS_D` +: `NBITS_D`].
- `o_grant`  out  `NREQ`  one-hot, high for exactly one cycle when a source's word is captured.
- `o_busy`  out  1  high from capture until the frame's last `i_tx_done`.
- `o_tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `o_tx_data`  out  `DBIT`  byte to `uart_tx`; stable from the start pulse until the matching done.
- `i_tx_done`  in  1  one-cycle done pulse from `uart_tx`.
- `o_frame_cnt`  out  8  completed frames, wraps modulo 256.

## Operation
- FSM states: IDLE, S_HDR, W_HDR, S_LO, W_LO, S_HI, W_HI. All outputs are registered.
- **IDLE**
  - If `|i_req` at an edge: choose winner k, capture `i_data` word k into `word_q`, set `last_q`=k, pulse `o_grant[k]`, go to S_HDR.
  - Otherwise stay in IDLE.
- **Arbitration:** round-robin. Search begins at (`last_q`+1) mod `NREQ` and takes the first set bit. `last_q` resets to `NREQ`-1, so source 0 wins first after reset.
- **S_x states** (HDR/LO/HI):
  - `o_tx_start`=1.
  - `o_tx_data` = {`TAG`, k[3:0]} for HDR, `word_q[7:0]` for LO, `word_q[15:8]` for HI.
  - Always advance to the matching W_x on the next edge.
- **W_x states:**
  - `o_tx_start`=0 and `o_tx_data` is held.
  - On an edge with `i_tx_done`=1: W_HDR→S_LO, W_LO→S_HI.
  - W_HI→IDLE, with `o_frame_cnt`+1 and `o_busy` cleared.
- `i_tx_done` in IDLE or any S_x state is ignored. No frame is aborted or shortened by spurious done pulses.
- `i_req` changes during a frame do not affect the frame in flight. `word_q` is frozen until the next grant.
- A requester that drops `i_req` before grant is simply not served.
- `NREQ`=1 degenerates to fixed grant of source 0 with tag {`TAG`,4'h0}.

## Timing
- **Reset (asynchronous, `i_reset`=0):**
  - state=IDLE, `o_grant`=0, `o_busy`=0, `o_tx_start`=0, `o_tx_data`=0, `o_frame_cnt`=0, `word_q`=0, `last_q`=`NREQ`-1.
  - Reset mid-frame drops the frame immediately. No partial byte is re-sent after release; the frame count is not incremented.
- **Grant latency:** request sampled high at edge E. In the cycle after E, `o_grant` and `o_busy` are high, state is S_HDR and `o_tx_start`=1 with the header byte.
- **Start pulses:** `o_tx_start` is high exactly one cycle per byte; three pulses per frame.
- **Byte-to-byte:** `i_tx_done` sampled at edge D. The next byte's `o_tx_start` is high in the cycle after D, so the minimum gap from done to next start is 1 cycle.
- **Frame end:** done of HI sampled at edge D. After D, state is IDLE, `o_busy`=0 and `o_frame_cnt` is updated.
- **Back-to-back:** a pending request is granted at edge D+1. There is at least one IDLE cycle between frames.
- **Simultaneous `i_req` and reset release:** the first grant occurs at the first edge with `i_reset`=1.

## Test plan
1. **Single request.** Reset, then `i_req`=2'b01, `i_data`[15:0]=16'h1234, `uart_tx` model done 5 cycles after each start.
   - Required: `o_grant`=01 for one cycle.
   - Bytes A0, 34, 12 in order with three one-cycle starts.
   - `o_frame_cnt`=1; `o_busy` low afterwards.
2. **Round robin.** `i_req`=2'b11 held continuously, words 16'hBEEF (src0) and 16'hCAFE (src1).
   - Required: frame sequence src0, src1, src0, src1 with headers A0, A1, A0, A1.
   - Exactly one IDLE cycle between frames.
3. **Data capture isolation.** Change `i_data` src0 to 16'h0000 one cycle after its grant.
   - Required: frame still carries EF, BE.
4. **Spurious done.** Inject `i_tx_done` in IDLE and in the S_LO cycle.
   - Required: no state advance, no extra or missing bytes, and the frame completes normally on real dones.
5. **Reset mid-frame.** Assert `i_reset`=0 in W_LO.
   - Required: all outputs are zero immediately, with `last_q` restored.
   - After release with `i_req`=2'b11, src0 is granted first and `o_frame_cnt` restarts from 0→1.
6. **Counter wrap.** Run 257 frames.
   - Required: `o_frame_cnt`=1 after the last frame.
